power_mode_sequencer: RTL and testbench

POWER_MODE_SEQUENCER -- requirements
Module: power_mode_sequencer

---
 rtl/power_mode_sequencer.sv | 113 +++++++++++
 tb/tb_power_mode_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/power_mode_sequencer.sv
// Power-down / power-up sequencer for one switchable domain.
// Moore FSM with a shared dwell counter; every output is registered.
module power_mode_sequencer #(
  parameter int GATE_DLY   = 2,
  parameter int RST_HOLD   = 3,
  parameter int SETTLE_DLY = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       sleep_req,
  input  logic       wake_req,
  output logic       iso_en,
  output logic       domain_clk_en,
  output logic       domain_rst_n,
  output logic       pwr_en,
  output logic       ack_o,
  output logic [1:0] mode_o
);

  typedef enum logic [2:0] {
    ACTIVE, ISO_ON, CLK_OFF, RST_ON, SLEEP, PWR_ON, CLK_ON, RST_OFF
  } state_t;

  localparam logic [7:0] GATE_LD   = 8'(GATE_DLY - 1);
  localparam logic [7:0] HOLD_LD   = 8'(RST_HOLD - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_DLY - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       waking, waking_nxt;
  logic       ack_nxt;
  logic [3:0] ctl_nxt;
  logic [1:0] mode_nxt;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
    waking_nxt = waking;
    ack_nxt    = 1'b0;
    case (state)
      ACTIVE:  if (sleep_req) begin
                 state_nxt = ISO_ON;
                 cnt_nxt   = 8'd0;
               end
      ISO_ON:  if (cnt == 8'd0) begin
                 state_nxt = CLK_OFF;
                 cnt_nxt   = GATE_LD;
               end
      CLK_OFF: if (cnt == 8'd0) begin
                 state_nxt = RST_ON;
                 cnt_nxt   = HOLD_LD;
               end
      RST_ON:  if (cnt == 8'd0) begin
                 state_nxt = SLEEP;
                 ack_nxt   = 1'b1;
               end
      SLEEP:   if (wake_req) begin
                 state_nxt  = PWR_ON;
                 cnt_nxt    = SETTLE_LD;
                 waking_nxt = 1'b1;
               end
      PWR_ON:  if (cnt == 8'd0) begin
                 state_nxt = CLK_ON;
                 cnt_nxt   = HOLD_LD;
               end
      CLK_ON:  if (cnt == 8'd0) begin
                 state_nxt = RST_OFF;
                 cnt_nxt   = 8'd1;
               end
      RST_OFF: if (cnt == 8'd0) begin
                 // only a requested wake is acknowledged, not reset recovery
                 state_nxt  = ACTIVE;
                 ack_nxt    = waking;
                 waking_nxt = 1'b0;
               end
      default: state_nxt = CLK_ON;
    endcase

    // {iso, clk_en, rst_n, pwr} decoded from the state being entered
    ctl_nxt  = 4'b1101;
    mode_nxt = 2'b11;
    case (state_nxt)
      ACTIVE:  begin ctl_nxt = 4'b0111; mode_nxt = 2'b00; end
      ISO_ON:  begin ctl_nxt = 4'b1111; mode_nxt = 2'b01; end
      CLK_OFF: begin ctl_nxt = 4'b1011; mode_nxt = 2'b01; end
      RST_ON:  begin ctl_nxt = 4'b1001; mode_nxt = 2'b01; end
      SLEEP:   begin ctl_nxt = 4'b1000; mode_nxt = 2'b10; end
      PWR_ON:  begin ctl_nxt = 4'b1001; mode_nxt = 2'b11; end
      CLK_ON:  begin ctl_nxt = 4'b1101; mode_nxt = 2'b11; end
      RST_OFF: begin ctl_nxt = 4'b1111; mode_nxt = 2'b11; end
      default: begin ctl_nxt = 4'b1101; mode_nxt = 2'b11; end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= CLK_ON;
      cnt    <= HOLD_LD;
      waking <= 1'b0;
      ack_o  <= 1'b0;
      {iso_en, domain_clk_en, domain_rst_n, pwr_en} <= 4'b1101;
      mode_o <= 2'b11;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      waking <= waking_nxt;
      ack_o  <= ack_nxt;
      {iso_en, domain_clk_en, domain_rst_n, pwr_en} <= ctl_nxt;
      mode_o <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_power_mode_sequencer.sv
// Bench: three sequencers (default, all-1 and all-255 dwells) on shared stimulus,
// each tracked by a schedule-queue model of expected per-cycle outputs.
module tb_power_mode_sequencer;

  // expected word: {ack, mode[1:0], iso, clk_en, rst_n, pwr}
  localparam logic [6:0] E_ACTIVE = 7'b0_00_0111;
  localparam logic [6:0] E_ISO    = 7'b0_01_1111;
  localparam logic [6:0] E_CLKOFF = 7'b0_01_1011;
  localparam logic [6:0] E_RSTON  = 7'b0_01_1001;
  localparam logic [6:0] E_SLEEP  = 7'b0_10_1000;
  localparam logic [6:0] E_PWRON  = 7'b0_11_1001;
  localparam logic [6:0] E_CLKON  = 7'b0_11_1101;
  localparam logic [6:0] E_RSTOFF = 7'b0_11_1111;
  localparam logic [6:0] E_ACK    = 7'b1_00_0000;

  logic clk_in = 1'b0;
  logic rst_in, sleep_req, wake_req;
  wire  [2:0] iso, ce, rn, pw, ack;
  wire  [5:0] md;

  int gd[3] = '{2, 1, 255};
  int rh[3] = '{3, 1, 255};
  int sd[3] = '{4, 1, 255};

  logic [6:0] plan [3][1024];
  int         ph[3], pt[3];
  logic [6:0] cur[3];
  bit         armed;
  int         n_chk, n_err;

  always #5 clk_in = ~clk_in;

  power_mode_sequencer #(.GATE_DLY(2), .RST_HOLD(3), .SETTLE_DLY(4)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .sleep_req(sleep_req), .wake_req(wake_req),
    .iso_en(iso[0]), .domain_clk_en(ce[0]), .domain_rst_n(rn[0]), .pwr_en(pw[0]),
    .ack_o(ack[0]), .mode_o(md[1:0]));
  power_mode_sequencer #(.GATE_DLY(1), .RST_HOLD(1), .SETTLE_DLY(1)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .sleep_req(sleep_req), .wake_req(wake_req),
    .iso_en(iso[1]), .domain_clk_en(ce[1]), .domain_rst_n(rn[1]), .pwr_en(pw[1]),
    .ack_o(ack[1]), .mode_o(md[3:2]));
  power_mode_sequencer #(.GATE_DLY(255), .RST_HOLD(255), .SETTLE_DLY(255)) u2 (
    .clk_in(clk_in), .rst_in(rst_in), .sleep_req(sleep_req), .wake_req(wake_req),
    .iso_en(iso[2]), .domain_clk_en(ce[2]), .domain_rst_n(rn[2]), .pwr_en(pw[2]),
    .ack_o(ack[2]), .mode_o(md[5:4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] obs(input int i);
    logic [6:0] r;
    case (i)
      0:       r = {ack[0], md[1:0], iso[0], ce[0], rn[0], pw[0]};
      1:       r = {ack[1], md[3:2], iso[1], ce[1], rn[1], pw[1]};
      default: r = {ack[2], md[5:4], iso[2], ce[2], rn[2], pw[2]};
    endcase
    return r;
  endfunction

  task automatic push(input int i, input logic [6:0] e, input int n);
    for (int k = 0; k < n; k++) begin
      plan[i][pt[i]] = e;
      pt[i]++;
    end
  endtask

  // One clock edge of the model: either follow the queued schedule or react
  // to a request while resting in ACTIVE / SLEEP.
  task automatic model(input int i);
    if (rst_in) begin
      cur[i] = E_CLKON;
      ph[i] = 0; pt[i] = 0;
      push(i, E_CLKON, rh[i] - 1);
      push(i, E_RSTOFF, 2);
      push(i, E_ACTIVE, 1);
    end else if (ph[i] != pt[i]) begin
      cur[i] = plan[i][ph[i]];
      ph[i]++;
      if (ph[i] == pt[i]) begin ph[i] = 0; pt[i] = 0; end
    end else if (cur[i][5:4] == 2'b00 && sleep_req) begin
      cur[i] = E_ISO;
      push(i, E_CLKOFF, gd[i]);
      push(i, E_RSTON, rh[i]);
      push(i, E_SLEEP | E_ACK, 1);
    end else if (cur[i][5:4] == 2'b10 && wake_req) begin
      cur[i] = E_PWRON;
      push(i, E_PWRON, sd[i] - 1);
      push(i, E_CLKON, rh[i]);
      push(i, E_RSTOFF, 2);
      push(i, E_ACTIVE | E_ACK, 1);
    end else begin
      cur[i][6] = 1'b0;
    end
  endtask

  task automatic cyc(input logic s, input logic w, input logic r);
    sleep_req = s; wake_req = w; rst_in = r;
    @(posedge clk_in);
    if (r) armed = 1'b1;
    for (int i = 0; i < 3; i++) model(i);
    @(negedge clk_in);
    if (armed)
      for (int i = 0; i < 3; i++) chk($sformatf("u%0d_out", i), obs(i), cur[i]);
  endtask

  initial begin
    int k, ackseen;
    int ngate[3], nrst[3];
    armed = 1'b0; n_chk = 0; n_err = 0;
    for (int i = 0; i < 3; i++) begin ph[i] = 0; pt[i] = 0; cur[i] = E_CLKON; end
    sleep_req = 1'b0; wake_req = 1'b0; rst_in = 1'b1;

    // reset two cycles, then count cycles to ACTIVE on the default instance
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_outputs", obs(0), E_CLKON);
    k = 0; ackseen = 0;
    while (k < 20 && obs(0) != E_ACTIVE) begin
      cyc(0, 0, 0);
      k++;
      if (ack[0]) ackseen = 1;
    end
    chk("rst_to_active", k, 5);
    chk("rst_no_ack", ackseen, 0);
    for (int c = 0; c < 600; c++) cyc(0, 0, 0);

    // sleep entry; wake pulsed during u0 CLK_OFF must be ignored
    cyc(1, 0, 0);
    k = 1;
    for (int i = 0; i < 3; i++) begin ngate[i] = 0; nrst[i] = 0; end
    while (k < 700 && !(md[1:0] == 2'b10 && md[3:2] == 2'b10 && md[5:4] == 2'b10)) begin
      for (int i = 0; i < 3; i++) begin
        if (obs(i) == E_CLKOFF) ngate[i]++;
        if (obs(i) == E_RSTON) nrst[i]++;
      end
      cyc(0, obs(0) == E_CLKOFF, 0);
      k++;
      if (k == 7) chk("entry_sleep_at_E6", obs(0), E_SLEEP | E_ACK);
      if (k == 8) chk("entry_ack_one_cycle", ack[0], 0);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_gate_dwell", i), ngate[i], gd[i]);
      chk($sformatf("u%0d_rst_dwell", i), nrst[i], rh[i]);
    end
    for (int c = 0; c < 3; c++) cyc(0, 0, 0);

    // wake with sleep_req held: re-entry begins on first ACTIVE cycle
    cyc(1, 1, 0);
    k = 1;
    while (k < 30 && obs(0) != (E_ACTIVE | E_ACK)) begin cyc(1, 0, 0); k++; end
    chk("wake_to_active", k, 10);
    cyc(1, 0, 0);
    chk("reentry_mode", md[1:0], 2'b01);
    k = 0;
    while (k < 1500 && !(md[1:0] == 2'b10 && md[5:4] == 2'b00)) begin cyc(0, 0, 0); k++; end

    // reset while sleeping
    cyc(0, 0, 1);
    chk("rst_in_sleep", obs(0), E_CLKON);
    k = 0;
    while (k < 20 && obs(0) != E_ACTIVE) begin cyc(0, 0, 0); k++; end
    chk("sleep_rst_to_active", k, 5);

    // randomized traffic
    for (int c = 0; c < 8000; c++)
      cyc($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(999) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
